// File: rtl/clock_pkg.sv
`default_nettype none
// ============================================================================
//  Package    : clock_pkg
//  Description: Shared types and constants for the digital clock time-set
//               path: sequencer state encoding, converter hold codes and
//               time field widths.
//  Revision   : 1.0 - initial release
// ============================================================================
package clock_pkg;

  // Sequencer states; the encoding is also the display-mux mode code
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_SET_HOUR = 2'd1,
    ST_SET_MIN  = 2'd2,
    ST_SET_SEC  = 2'd3
  } state_t;

  // Hold codes to the converters: [0] clear seconds, [1] minute edit, [2] hour edit
  localparam logic [2:0] HOLD_RUN  = 3'b000;
  localparam logic [2:0] HOLD_HOUR = 3'b100;
  localparam logic [2:0] HOLD_MIN  = 3'b010;
  localparam logic [2:0] HOLD_SEC  = 3'b001;

  // Field widths of the converter chain
  localparam int SEC_W  = 6;
  localparam int MIN_W  = 6;
  localparam int HOUR_W = 5;

  // Hold code presented to the converters while in a given state
  function automatic logic [2:0] hold_of(input state_t s);
    case (s)
      ST_SET_HOUR: hold_of = HOLD_HOUR;
      ST_SET_MIN:  hold_of = HOLD_MIN;
      ST_SET_SEC:  hold_of = HOLD_SEC;
      default:     hold_of = HOLD_RUN;
    endcase
  endfunction

  // Mode-button sequence RUN -> SET_HOUR -> SET_MIN -> SET_SEC -> RUN
  function automatic state_t next_mode(input state_t s);
    case (s)
      ST_RUN:      next_mode = ST_SET_HOUR;
      ST_SET_HOUR: next_mode = ST_SET_MIN;
      ST_SET_MIN:  next_mode = ST_SET_SEC;
      default:     next_mode = ST_RUN;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/time_set_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Interface  : time_set_ctrl_if
//  Description: Button/tick inputs and converter-control outputs of the
//               time-set sequencer. The slave modport is the sequencer side.
//  Revision   : 1.0 - initial release
// ============================================================================
interface time_set_ctrl_if;

  logic       tick_1hz;
  logic       btn_mode;
  logic       btn_inc;
  logic [2:0] hold;
  logic       min_inc;
  logic       hour_inc;
  logic [1:0] mode;
  logic       blink;

  modport slave (
    input  tick_1hz, btn_mode, btn_inc,
    output hold, min_inc, hour_inc, mode, blink
  );

  modport master (
    output tick_1hz, btn_mode, btn_inc,
    input  hold, min_inc, hour_inc, mode, blink
  );

endinterface
`default_nettype wire

// File: rtl/btn_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module     : btn_sync_edge
//  Description: Multi-flop synchroniser for an asynchronous active-high
//               button followed by a registered rising-edge detector.
//               Pulse appears SYNC_STAGES+1 clocks after the pin rises.
//  Revision   : 1.0 - initial release
// ============================================================================
module btn_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;

  generate
    if (SYNC_STAGES < 2) begin : g_bad_stages
      $error("btn_sync_edge: SYNC_STAGES must be at least 2");
    end
  endgenerate

  // Sync chain and edge history reset to the pressed level, so a button
  // held through reset is seen as already high and yields no edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= '1;
      prev  <= 1'b1;
      pulse <= 1'b0;
    end else begin
      sync  <= {sync[SYNC_STAGES-2:0], btn};
      prev  <= sync[SYNC_STAGES-1];
      pulse <= sync[SYNC_STAGES-1] & ~prev;
    end
  end

endmodule
`default_nettype wire

// File: rtl/time_set_ctrl.sv
`default_nettype none
// ============================================================================
//  Module     : time_set_ctrl
//  Description: Mode/time-set sequencer for the digital clock. Turns the
//               mode and inc buttons into converter hold codes, one-clock
//               minute/hour increment strobes, a mode code and a blink
//               enable for the field under edit.
//               Optional feature macro: SET_TIMEOUT_EN - idle timeout that
//               returns a SET_* mode to RUN after TIMEOUT_S seconds.
//  Revision   : 1.0 - initial release
// ============================================================================
module time_set_ctrl
  import clock_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_S   = 30
) (
  input  logic            clk,
  input  logic            rst_n,
  time_set_ctrl_if.slave  bus
);

  logic   mode_p;
  logic   inc_p;
  logic   expire;
  state_t state, state_nx;
  logic [2:0] hold_r;
  logic   min_inc_r, min_inc_nx;
  logic   hour_inc_r, hour_inc_nx;
  logic   blink_r, blink_nx;

  generate
    if (TIMEOUT_S < 1) begin : g_bad_timeout
      $error("time_set_ctrl: TIMEOUT_S must be at least 1");
    end
  endgenerate

  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_mode_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (bus.btn_mode),
    .pulse (mode_p)
  );

  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_inc_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (bus.btn_inc),
    .pulse (inc_p)
  );

`ifdef SET_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_S + 1);
  logic [CNT_W-1:0] idle_cnt, idle_cnt_nx;

  assign expire = (state != ST_RUN) && (idle_cnt == CNT_W'(TIMEOUT_S));

  // Seconds since the last button edge while editing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) idle_cnt <= '0;
    else        idle_cnt <= idle_cnt_nx;
  end
`else
  assign expire = 1'b0;
`endif

  // State, hold decode, strobes and blink, all registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_RUN;
      hold_r     <= HOLD_RUN;
      min_inc_r  <= 1'b0;
      hour_inc_r <= 1'b0;
      blink_r    <= 1'b1;
    end else begin
      state      <= state_nx;
      hold_r     <= hold_of(state_nx);
      min_inc_r  <= min_inc_nx;
      hour_inc_r <= hour_inc_nx;
      blink_r    <= blink_nx;
    end
  end

  // Next state: mode_p wins over timeout, both suppress any strobe;
  // strobes and blink toggling only happen while the state holds.
  always_comb begin
    state_nx    = state;
    min_inc_nx  = 1'b0;
    hour_inc_nx = 1'b0;
    blink_nx    = blink_r;
`ifdef SET_TIMEOUT_EN
    idle_cnt_nx = idle_cnt;
`endif
    if (mode_p) begin
      state_nx = next_mode(state);
      blink_nx = 1'b1;
`ifdef SET_TIMEOUT_EN
      idle_cnt_nx = '0;
`endif
    end else if (expire) begin
      state_nx = ST_RUN;
      blink_nx = 1'b1;
`ifdef SET_TIMEOUT_EN
      idle_cnt_nx = '0;
`endif
    end else begin
      hour_inc_nx = inc_p && (state == ST_SET_HOUR);
      min_inc_nx  = inc_p && (state == ST_SET_MIN);
      if (state == ST_RUN)    blink_nx = 1'b1;
      else if (bus.tick_1hz)  blink_nx = ~blink_r;
`ifdef SET_TIMEOUT_EN
      if (state == ST_RUN || inc_p) idle_cnt_nx = '0;
      else if (bus.tick_1hz)        idle_cnt_nx = idle_cnt + 1'b1;
`endif
    end
  end

  assign bus.mode     = state;
  assign bus.hold     = hold_r;
  assign bus.min_inc  = min_inc_r;
  assign bus.hour_inc = hour_inc_r;
  assign bus.blink    = blink_r;

endmodule
`default_nettype wire

// File: tb/tb_time_set_ctrl.sv
`default_nettype none
// ============================================================================
//  Module     : tb_time_set_ctrl
//  Description: Self-checking bench for time_set_ctrl: per-cycle reference
//               model, table of button actions, hand-written corner cases
//               and a randomized phase.
//  Revision   : 1.0 - initial release
// ============================================================================
module tb_time_set_ctrl;

  localparam int SYNC = 2;
`ifdef SET_TIMEOUT_EN
  localparam int TO = 3;
`else
  localparam int TO = 30;
`endif

  logic clk = 1'b0;
  logic rst_n;
  time_set_ctrl_if bus();

  time_set_ctrl #(.SYNC_STAGES(SYNC), .TIMEOUT_S(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: mode counter 0..3, blink, strobes, idle seconds,
  // plus the pin levels seen at each clock (newest first).
  int   m_md, m_idle;
  bit   m_blink, m_hi, m_mi;
  bit   hist_m[$], hist_i[$];
  logic [2:0] hold_tab [4];
  int   hcnt, mcnt;

  typedef struct {
    bit         do_mode;
    bit         do_inc;
    bit         do_tick;
    logic [1:0] e_mode;
    logic [2:0] e_hold;
    int         e_hour;
    int         e_min;
    bit         e_blink;
  } vec_t;
  vec_t tbl [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_md = 0; m_idle = 0; m_blink = 1; m_hi = 0; m_mi = 0;
    hist_m.delete(); hist_i.delete();
    for (int k = 0; k < SYNC + 3; k++) begin
      hist_m.push_front(1'b1);
      hist_i.push_front(1'b1);
    end
  endtask

  // One clock edge: a button edge counts SYNC+1 clocks after the pin is sampled high
  task automatic model_step(input bit pm, input bit pi, input bit tk);
    bit mp, ip;
    if (!rst_n) begin
      model_reset();
      return;
    end
    hist_m.push_front(pm); void'(hist_m.pop_back());
    hist_i.push_front(pi); void'(hist_i.pop_back());
    mp = hist_m[SYNC+1] && !hist_m[SYNC+2];
    ip = hist_i[SYNC+1] && !hist_i[SYNC+2];
    m_hi = 0; m_mi = 0;
`ifdef SET_TIMEOUT_EN
    if (!mp && m_md != 0 && m_idle == TO) begin
      m_md = 0; m_blink = 1; m_idle = 0;
      return;
    end
`endif
    if (mp) begin
      m_md = (m_md + 1) % 4; m_blink = 1; m_idle = 0;
    end else begin
      m_hi = ip && (m_md == 1);
      m_mi = ip && (m_md == 2);
      if (m_md == 0) m_blink = 1;
      else if (tk)   m_blink = !m_blink;
      if (m_md == 0 || ip) m_idle = 0;
      else if (tk)         m_idle++;
    end
  endtask

  // Called at a negedge: drive inputs, clock once, check at the next negedge
  task automatic cyc(input bit m, input bit i, input bit t);
    bus.btn_mode = m; bus.btn_inc = i; bus.tick_1hz = t;
    @(posedge clk);
    model_step(m, i, t);
    @(negedge clk);
    chk("cycle", {bus.mode, bus.hold, bus.min_inc, bus.hour_inc, bus.blink},
        {m_md[1:0], hold_tab[m_md], m_mi, m_hi, m_blink});
    hcnt += int'(bus.hour_inc);
    mcnt += int'(bus.min_inc);
  endtask

  task automatic press(input bit m, input bit i);
    cyc(m, i, 0);
    repeat (SYNC + 3) cyc(0, 0, 0);
  endtask

  initial begin
    hold_tab[0] = 3'b000; hold_tab[1] = 3'b100; hold_tab[2] = 3'b010; hold_tab[3] = 3'b001;
    //        mode inc tick  e_mode e_hold  hr mn bl
    tbl[0]  = '{0, 1, 0, 2'd0, 3'b000, 0, 0, 1};
    tbl[1]  = '{0, 0, 1, 2'd0, 3'b000, 0, 0, 1};
    tbl[2]  = '{1, 0, 0, 2'd1, 3'b100, 0, 0, 1};
    tbl[3]  = '{0, 1, 0, 2'd1, 3'b100, 1, 0, 1};
    tbl[4]  = '{0, 1, 0, 2'd1, 3'b100, 1, 0, 1};
    tbl[5]  = '{0, 1, 0, 2'd1, 3'b100, 1, 0, 1};
    tbl[6]  = '{1, 0, 0, 2'd2, 3'b010, 0, 0, 1};
    tbl[7]  = '{0, 0, 1, 2'd2, 3'b010, 0, 0, 0};
    tbl[8]  = '{0, 0, 1, 2'd2, 3'b010, 0, 0, 1};
    tbl[9]  = '{0, 1, 0, 2'd2, 3'b010, 0, 1, 1};
    tbl[10] = '{0, 0, 1, 2'd2, 3'b010, 0, 0, 0};
    tbl[11] = '{0, 0, 1, 2'd2, 3'b010, 0, 0, 1};
    tbl[12] = '{1, 0, 0, 2'd3, 3'b001, 0, 0, 1};
    tbl[13] = '{0, 1, 0, 2'd3, 3'b001, 0, 0, 1};
    tbl[14] = '{0, 0, 1, 2'd3, 3'b001, 0, 0, 0};
    tbl[15] = '{1, 0, 0, 2'd0, 3'b000, 0, 0, 1};

    bus.btn_mode = 0; bus.btn_inc = 0; bus.tick_1hz = 0;
    rst_n = 0;
    model_reset();
    hcnt = 0; mcnt = 0;
    @(negedge clk);
    repeat (2) cyc(0, 0, 0);
    chk("reset_state", {bus.mode, bus.hold, bus.min_inc, bus.hour_inc, bus.blink}, 8'b00_000_001);
    rst_n = 1;
    repeat (4) cyc(0, 0, 0);

    // Table of single actions with settled expectations
    for (int n = 0; n < 16; n++) begin
      hcnt = 0; mcnt = 0;
      cyc(tbl[n].do_mode, tbl[n].do_inc, tbl[n].do_tick);
      repeat (SYNC + 3) cyc(0, 0, 0);
      chk($sformatf("tbl%0d_out", n), {bus.mode, bus.hold, bus.blink},
          {tbl[n].e_mode, tbl[n].e_hold, tbl[n].e_blink});
      chk($sformatf("tbl%0d_strobes", n), {hcnt[15:0], mcnt[15:0]},
          {tbl[n].e_hour[15:0], tbl[n].e_min[15:0]});
    end

    // Mode change lands on the SYNC+2-th clock after the pin rises
    cyc(1, 0, 0);
    repeat (SYNC) cyc(0, 0, 0);
    chk("latency_before", {bus.mode, bus.hold}, {2'd0, 3'b000});
    cyc(0, 0, 0);
    chk("latency_after", {bus.mode, bus.hold}, {2'd1, 3'b100});
    repeat (3) cyc(0, 0, 0);

    // Collision in SET_MIN: state advances, min strobe dropped, blink re-forced
    press(1, 0);
    cyc(0, 0, 1);
    chk("coll_pre_blink", bus.blink, 1'b0);
    hcnt = 0; mcnt = 0;
    press(1, 1);
    chk("coll_state", {bus.mode, bus.hold, bus.blink}, {2'd3, 3'b001, 1'b1});
    chk("coll_no_strobe", {hcnt[15:0], mcnt[15:0]}, 32'd0);
    press(1, 0);

    // Async reset mid-SET_MIN with inc held
    press(1, 0); press(1, 0);
    chk("pre_reset_min", bus.mode, 2'd2);
    bus.btn_inc = 1;
    rst_n = 0;
    #1;
    chk("async_reset", {bus.mode, bus.hold, bus.min_inc, bus.hour_inc, bus.blink}, 8'b00_000_001);
    model_reset();
    @(negedge clk);
    repeat (3) cyc(0, 1, 0);
    rst_n = 1;
    hcnt = 0; mcnt = 0;
    repeat (6) cyc(0, 1, 0);
    repeat (4) cyc(0, 0, 0);
    chk("post_reset", {bus.mode, bus.hold, hcnt[7:0], mcnt[7:0]}, {2'd0, 3'b000, 16'd0});

    // Mode button held through reset gives no edge
    rst_n = 0;
    repeat (3) cyc(1, 0, 0);
    rst_n = 1;
    repeat (8) cyc(1, 0, 0);
    chk("held_mode_no_edge", bus.mode, 2'd0);
    repeat (4) cyc(0, 0, 0);
    chk("held_mode_release", bus.mode, 2'd0);

`ifdef SET_TIMEOUT_EN
    // Idle timeout with an inc restarting the count
    press(1, 0);
    cyc(0, 0, 1); cyc(0, 0, 1);
    chk("to_two_ticks", bus.mode, 2'd1);
    hcnt = 0;
    press(0, 1);
    chk("to_inc_strobe", hcnt, 1);
    cyc(0, 0, 1); cyc(0, 0, 1);
    chk("to_restarted", bus.mode, 2'd1);
    cyc(0, 0, 1);
    chk("to_third_tick", bus.mode, 2'd1);
    cyc(0, 0, 0);
    chk("to_expired", {bus.mode, bus.hold, bus.blink}, {2'd0, 3'b000, 1'b1});
`endif

    // Randomized buttons (sticky levels) and ticks against the model
    begin
      bit pm, pi, tk;
      pm = 0; pi = 0;
      for (int n = 0; n < 4000; n++) begin
        if ($urandom_range(0, 5) == 0) pm = !pm;
        if ($urandom_range(0, 4) == 0) pi = !pi;
        tk = ($urandom_range(0, 7) == 0);
        cyc(pm, pi, tk);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
